unary_decode: RTL and testbench

//  Streaming thermometer-to-binary decoder; the inverse of the unary encoder stage in the svlib DTI pipelines.

---
 rtl/unary_decode.sv | 124 ++++++++++++
 tb/tb_unary_decode.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/unary_decode.sv
// Streaming thermometer-to-binary decoder. A thermometer word is latched, then scanned
// CHUNK bits per cycle (LSB chunk first) to produce the count of contiguous ones from bit 0
// plus a sticky error flag for non-contiguous codes. Result is held until handshaked.
module unary_decode #(
  parameter int unsigned W_UNARY = 16,
  parameter int unsigned CHUNK   = 4,
  parameter int unsigned W_DATA  = $clog2(W_UNARY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W_UNARY-1:0]  din_data,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [W_DATA:0]     dout_data,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam int unsigned NCHUNK = W_UNARY / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    chunk_idx_q, chunk_idx_d;
  logic [W_UNARY-1:0] shreg_q, shreg_d;
  logic [W_DATA-1:0]  count_q, count_d;
  logic               err_q, err_d;
  logic               seen_zero_q, seen_zero_d;

  logic [W_DATA-1:0]  scan_count;
  logic               scan_err;
  logic               scan_seen_zero;
  logic               last_chunk;

  // Ready depends only on state and reset, never on dout_ready.
  assign din_ready  = (state_q == StIdle) && !rst;
  assign dout_valid = (state_q == StDone);
  // count/err are frozen outside SCAN, so the result is stable throughout DONE.
  assign dout_data  = {err_q, count_q};
  assign last_chunk = (chunk_idx_q == IdxW'(NCHUNK - 1));

  // Walk the low CHUNK bits of the shift register, carrying seen_zero across chunks.
  always_comb begin
    scan_count     = count_q;
    scan_err       = err_q;
    scan_seen_zero = seen_zero_q;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (shreg_q[i]) begin
        if (scan_seen_zero) begin
          scan_err = 1'b1;
        end else begin
          scan_count = scan_count + W_DATA'(1);
        end
      end else begin
        scan_seen_zero = 1'b1;
      end
    end
  end

  // Next-state logic for the IDLE -> SCAN x NCHUNK -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    chunk_idx_d = chunk_idx_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    err_d       = err_q;
    seen_zero_d = seen_zero_q;
    case (state_q)
      StIdle: begin
        if (din_valid && din_ready) begin
          shreg_d     = din_data;
          chunk_idx_d = '0;
          count_d     = '0;
          err_d       = 1'b0;
          seen_zero_d = 1'b0;
          state_d     = StScan;
        end
      end
      StScan: begin
        count_d     = scan_count;
        err_d       = scan_err;
        seen_zero_d = scan_seen_zero;
        shreg_d     = shreg_q >> CHUNK;
        if (last_chunk) begin
          chunk_idx_d = '0;
          state_d     = StDone;
        end else begin
          chunk_idx_d = chunk_idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (dout_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; synchronous reset aborts any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      chunk_idx_q <= '0;
      shreg_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      seen_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_idx_q <= chunk_idx_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      err_q       <= err_d;
      seen_zero_q <= seen_zero_d;
    end
  end

endmodule

// File: tb/tb_unary_decode.sv
// Randomized self-checking bench for unary_decode at W_UNARY=16, CHUNK=4.
module tb_unary_decode;

  localparam int unsigned WU = 16;
  localparam int unsigned WD = 5;
  localparam int unsigned NCH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [WU-1:0] din_data;
  logic          din_valid;
  logic          din_ready;
  logic [WD:0]   dout_data;
  logic          dout_valid;
  logic          dout_ready;

  int n_checks = 0;
  int n_pass   = 0;

  unary_decode #(
    .W_UNARY (WU),
    .CHUNK   (4),
    .W_DATA  (WD)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: count trailing ones; the word is well-formed iff it equals 2^k - 1.
  function automatic logic [WD:0] ref_decode(input logic [WU-1:0] w);
    int          k;
    logic [31:0] full;
    logic        err;
    k = 0;
    while (k < int'(WU) && w[k]) k++;
    full = (32'd1 << k) - 32'd1;
    err  = ({16'h0, w} != full);
    return {err, WD'(k)};
  endfunction

  function automatic logic [WU-1:0] gen_word();
    logic [WU-1:0] w;
    int            k;
    case ($urandom_range(0, 2))
      0: begin
        k = $urandom_range(0, WU);
        w = WU'((32'd1 << k) - 32'd1);
      end
      1: begin
        k = $urandom_range(0, WU);
        w = WU'((32'd1 << k) - 32'd1);
        w[$urandom_range(0, WU - 1)] ^= 1'b1;
      end
      default: w = WU'($urandom);
    endcase
    return w;
  endfunction

  // One full transaction with optional DONE stall; checks latency, result and hold behaviour.
  task automatic run_word(input logic [WU-1:0] w, input int stall);
    int          guard;
    int          lat;
    logic [WD:0] exp;
    exp = ref_decode(w);
    @(negedge clk);
    din_data   = w;
    din_valid  = 1'b1;
    dout_ready = 1'b0;
    guard = 0;
    while (!din_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", guard < 20, 1);
    @(negedge clk);
    din_valid = 1'b0;
    lat = 1;
    while (!dout_valid && lat < 20) begin
      check("scan_din_ready", din_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NCH + 1);
    check("result", dout_data, exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", dout_valid, 1);
      check("hold_data", dout_data, exp);
      check("hold_din_ready", din_ready, 0);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    check("release_valid", dout_valid, 0);
    check("release_din_ready", din_ready, 1);
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [WU-1:0] words [12];
    logic [WD:0]   exp_q [$];
    int            acc_cnt;
    int            done_cnt;
    int            cyc;
    int            last_acc;
    logic          adv;

    rst        = 1'b1;
    din_data   = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout_data", dout_data, 0);
    check("reset_din_ready", din_ready, 0);
    rst = 1'b0;
    #1;
    check("post_reset_din_ready", din_ready, 1);

    run_word(16'h0000, 0);
    run_word(16'h00FF, 0);
    run_word(16'hFFFF, 0);
    run_word(16'h00F7, 0);
    run_word(16'h8000, 0);
    run_word(16'h003F, 3);

    for (int i = 0; i < 20; i++) begin
      run_word(gen_word(), $urandom_range(0, 3));
    end

    // Back-to-back: din_valid held high, dout_ready high.
    for (int i = 0; i < 12; i++) words[i] = gen_word();
    acc_cnt  = 0;
    done_cnt = 0;
    cyc      = 0;
    last_acc = -1;
    adv      = 1'b0;
    @(negedge clk);
    din_data   = words[0];
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    while (done_cnt < 12 && cyc < 300) begin
      if (din_valid && din_ready) begin
        exp_q.push_back(ref_decode(din_data));
        if (last_acc >= 0) check("b2b_interval", cyc - last_acc, NCH + 2);
        last_acc = cyc;
        acc_cnt++;
        adv = 1'b1;
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_spurious", 1, 0);
        end else begin
          check("b2b_data", dout_data, exp_q.pop_front());
        end
        done_cnt++;
      end
      @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 1'b0;
        if (acc_cnt < 12) din_data = words[acc_cnt];
        else din_valid = 1'b0;
      end
    end
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    check("b2b_results", done_cnt, 12);
    check("b2b_accepts", acc_cnt, 12);

    // Reset during the second SCAN cycle aborts the word.
    @(negedge clk);
    din_data  = 16'h0FFF;
    din_valid = 1'b1;
    check("abort_accept_ready", din_ready, 1);
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_din_ready", din_ready, 0);
    check("abort_rst_valid", dout_valid, 0);
    rst = 1'b0;
    dout_ready = 1'b1;
    #1;
    check("abort_idle_ready", din_ready, 1);
    check("abort_idle_valid", dout_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_output", dout_valid, 0);
    end
    dout_ready = 1'b0;
    run_word(16'h0003, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
